// File: rtl/bp_pkg.sv
// Shared types and helpers for the 2-bit saturating branch history table.
// Counter encoding: 00 strongly not-taken .. 11 strongly taken; prediction is the MSB.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_state_e;

  localparam cnt_state_e CNT_RST = WNT;

  function automatic cnt_state_e sat_update(input cnt_state_e cur, input logic taken);
    cnt_state_e nxt;
    nxt = cur;
    unique case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = CNT_RST;
    endcase
    return nxt;
  endfunction

  function automatic logic cnt_predict(input cnt_state_e cur);
    return cur[1];
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Array of 2-bit saturating counters with one registered read port and one
// saturating-update write port. Reads see the pre-update value on a same-index collision.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en_i,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_taken_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic                  wr_taken_i
);

  localparam int NUM = 1 << INDEX_BITS;

  cnt_state_e cnt_q [NUM];
  cnt_state_e wr_cnt_d;
  logic       rd_taken_q;
  logic       rd_taken_d;

  always_comb begin
    wr_cnt_d = sat_update(cnt_q[wr_idx_i], wr_taken_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) begin
        cnt_q[i] <= CNT_RST;
      end
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= wr_cnt_d;
    end
  end

  // Holds the last prediction when no lookup is issued.
  always_comb begin
    rd_taken_d = rd_taken_q;
    if (rd_en_i) begin
      rd_taken_d = cnt_predict(cnt_q[rd_idx_i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_taken_q <= 1'b0;
    end else begin
      rd_taken_q <= rd_taken_d;
    end
  end

  assign rd_taken_o = rd_taken_q;

endmodule

// File: rtl/branch_predictor_bht.sv
// Bimodal branch history table: PC-indexed lookup with 1-cycle registered result,
// training from the resolution unit, and a saturating mispredict counter.
// Define BP_GSHARE_EN to XOR a global history register into the lookup index.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_W     = 64,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pred_valid,
  input  logic [ADDR_W-1:0]     pred_pc,
  output logic                  pred_out_valid,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  output logic [CNT_W-1:0]      mispredict_count
);

  logic [INDEX_BITS-1:0] pc_idx;
  logic [INDEX_BITS-1:0] lkp_idx;

  logic                  out_valid_q, out_valid_d;
  logic [INDEX_BITS-1:0] out_index_q, out_index_d;
  logic [CNT_W-1:0]      mis_cnt_q, mis_cnt_d;

  // Instructions are 4-byte aligned, so PC[1:0] carries no information.
  assign pc_idx = pred_pc[INDEX_BITS+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[ADDR_W-1:INDEX_BITS+2], pred_pc[1:0]};

`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q, ghr_d;

  // History advances only on resolved branches; a same-cycle lookup sees the old value.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid) begin
      ghr_d = {ghr_q[INDEX_BITS-2:0], upd_taken};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign lkp_idx = pc_idx ^ ghr_q;
`else
  assign lkp_idx = pc_idx;
`endif

  always_comb begin
    out_valid_d = pred_valid;
    out_index_d = out_index_q;
    if (pred_valid) begin
      out_index_d = lkp_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_index_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
    end
  end

  // Resolution unit is authoritative for mispredicts; count saturates instead of wrapping.
  always_comb begin
    mis_cnt_d = mis_cnt_q;
    if (upd_valid && upd_mispredict && (mis_cnt_q != {CNT_W{1'b1}})) begin
      mis_cnt_d = mis_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_cnt_q <= '0;
    end else begin
      mis_cnt_q <= mis_cnt_d;
    end
  end

  bp_counter_table #(
    .INDEX_BITS (INDEX_BITS)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (pred_valid),
    .rd_idx_i   (lkp_idx),
    .rd_taken_o (pred_taken),
    .wr_en_i    (upd_valid),
    .wr_idx_i   (upd_index),
    .wr_taken_i (upd_taken)
  );

  assign pred_out_valid   = out_valid_q;
  assign pred_index       = out_index_q;
  assign mispredict_count = mis_cnt_q;

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Prediction end of the branch path: issues the taken/not-taken guess that the branch resolution unit later checks against the actual decision.
- Holds a table of 2-bit saturating counters indexed by fetch PC.
- Answers fetch-stage lookups with a 1-cycle registered prediction.
- Is trained by the resolution unit's outcome (actual decision plus mispredict/flush) and keeps a mispredict statistic.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64 counters).
- ADDR_W, 64, PC width.
- CNT_W, 16, width of the mispredict statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pred_valid  in  1  lookup request this cycle.
- pred_pc  in  ADDR_W  PC of the branch being fetched.
- pred_out_valid  out  1  pred_taken/pred_index valid (pred_valid delayed 1 cycle).
- pred_taken  out  1  predicted direction; feeds the resolution unit's branch_taken.
- pred_index  out  INDEX_BITS  table index used; carried down the pipe and returned on upd_index.
- upd_valid  in  1  resolved branch update this cycle.
- upd_index  in  INDEX_BITS  index returned from pred_index.
- upd_taken  in  1  actual branch decision.
- upd_mispredict  in  1  resolution unit flagged flush (prediction_success low).
- mispredict_count  out  CNT_W  saturating count of mispredicts since reset.

Behaviour:
- Reset (async, immediate):
  - All counters = 2'b01 (weakly not-taken).
  - pred_out_valid = 0, pred_taken = 0, pred_index = 0, mispredict_count = 0.
  - GHR = 0 when GSHARE_EN is defined.
- Index: idx = pred_pc[INDEX_BITS+1:2]. PC bits [1:0] are ignored (4-byte instructions).
- Lookup latency is 1 cycle. On the edge where pred_valid = 1:
  - pred_taken <= table[idx][1]; pred_index <= idx; pred_out_valid <= 1.
  - When pred_valid = 0: pred_out_valid <= 0; pred_taken and pred_index hold their previous values.
- Update, on the edge where upd_valid = 1:
  - upd_taken = 1: table[upd_index] increments, saturating at 2'b11.
  - upd_taken = 0: table[upd_index] decrements, saturating at 2'b00.
- Counter states: 00 SNT, 01 WNT, 10 WT, 11 ST. The prediction is the MSB.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update value (no bypass). The update commits in the same edge.
- Simultaneous lookup and update to different indices are independent.
- mispredict_count increments on upd_valid & upd_mispredict and saturates at all-ones (no wrap). upd_mispredict without upd_valid is ignored.
- The predictor does not verify upd_mispredict against its own counters; the resolution unit is authoritative.
- Reset asserted mid-operation aborts any in-flight lookup: pred_out_valid drops to 0 immediately.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - An INDEX_BITS-wide global history register (GHR) is added.
  - Lookup idx = pred_pc[INDEX_BITS+1:2] XOR GHR.
  - On upd_valid, GHR <= {GHR[INDEX_BITS-2:0], upd_taken}. Update is non-speculative, at resolution only.
  - upd_index is still used verbatim for training.
  - A lookup in the same cycle as an update uses the pre-shift GHR.
- Not defined: no GHR flops exist; idx is the PC bits only.

Decomposition:
- Package bp_pkg:
  - Counter state constants SNT/WNT/WT/ST.
  - Reset value WNT.
  - A sat_update function (2-bit counter, direction -> next state).
- One sub-module is natural: bp_counter_table.
  - Contains the counter array with async reset.
  - One registered read port and one write port with saturating update.
- The top level holds index/GHR logic, output registers and the statistics counter.

Test Plan:
- Reset, then lookup pred_pc=0x1000 -> next cycle pred_out_valid=1, pred_taken=0, pred_index=0 (0x1000>>2 & 63); mispredict_count=0.
- Two updates upd_index=0, upd_taken=1, then lookup 0x1000 -> pred_taken=1. Then three more taken updates and one not-taken update -> still pred_taken=1 (saturated at ST, now WT).
- Five not-taken updates on index 5, then one taken update -> counter=01, lookup pred_pc=0x14 gives pred_taken=0 (saturation at 00 verified).
- Same-cycle lookup and update on index 3, counter=01, upd_taken=1 -> this lookup returns 0; the following lookup returns 1.
- Ten cycles of upd_valid=1, upd_mispredict=1, then one cycle upd_mispredict=1 with upd_valid=0 -> mispredict_count=10. Force the count to 0xFFFF and issue one more -> stays 0xFFFF.
- BP_GSHARE_EN defined: updates taken,taken (GHR=6'b000011), lookup pred_pc=0x0 -> pred_index=3. Assert rst during a pending lookup -> pred_out_valid=0 immediately and GHR=0.
